// File: rtl/wrd_pkg.sv
// Shared definitions for the wake-word CNN datapath stages.
//   BW         : default sample width (signed two's complement)
//   max_signed : signed maximum of two samples; on a tie the first operand is
//                returned, so a stored running maximum is kept.
package wrd_pkg;

    localparam int BW = 32;

    function automatic logic [BW-1:0] max_signed(input logic [BW-1:0] a,
                                                 input logic [BW-1:0] b);
        return ($signed(b) > $signed(a)) ? b : a;
    endfunction

endpackage

// File: rtl/max_pool_acc_mem.sv
// Running-maximum register file for max_pool: one BW-wide entry per channel.
//   clk_i   : clock
//   we_i    : write enable (synchronous write on posedge)
//   waddr_i : write channel index
//   wdata_i : write data
//   raddr_i : read channel index (combinational read)
//   rdata_o : read data
module max_pool_acc_mem
    import wrd_pkg::*;
#(
    parameter int BW     = wrd_pkg::BW,
    parameter int NUM_CH = 8,
    localparam int AW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [BW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [BW-1:0] rdata_o
);

    logic [BW-1:0] mem_q [NUM_CH];

    // NOTE: no reset on the storage array; the first frame of every window
    // overwrites each entry before it is ever read, so a reset would only add
    // fan-out on the reset net.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pool.sv
// 1-D temporal max pooling over a channel-interleaved stream.
// One running maximum per channel over POOL_SIZE frames; stride = POOL_SIZE.
//   clk_i   : clock, all logic on posedge
//   rst_n_i : synchronous active-low reset
//   data_i  : signed input sample        valid_i : input beat valid
//   last_i  : final beat of sequence     ready_o : input accepted this cycle
//   data_o  : signed pooled maximum      valid_o : output beat valid
//   last_o  : final pooled beat          ready_i : downstream accepts output
//   trunc_o : 1-cycle pulse, sequence ended mid-window and the partial window was dropped
module max_pool
    import wrd_pkg::*;
#(
    parameter int BW        = wrd_pkg::BW,
    parameter int NUM_CH    = 8,
    parameter int POOL_SIZE = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [BW-1:0] data_i,
    input  logic          valid_i,
    input  logic          last_i,
    output logic          ready_o,
    output logic [BW-1:0] data_o,
    output logic          valid_o,
    output logic          last_o,
    input  logic          ready_i,
    output logic          trunc_o
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;

    logic [CW-1:0] ch_cnt_q, ch_cnt_d;
    logic [FW-1:0] frm_cnt_q, frm_cnt_d;
    logic [BW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          trunc_q, trunc_d;

    logic          accept;
    logic          ch_last;
    logic          frm_first;
    logic          frm_last;
    logic          acc_we;
    logic [BW-1:0] acc_rdata;
    logic [BW-1:0] pooled;

    // A held output blocks every input beat, even ones that would only fold
    // into the accumulator, so the stream stays in lock-step with the output.
    assign ready_o   = !valid_q || ready_i;
    assign accept    = valid_i && ready_o;

    assign ch_last   = (ch_cnt_q == CW'(NUM_CH - 1));
    assign frm_first = (frm_cnt_q == '0);
    assign frm_last  = (frm_cnt_q == FW'(POOL_SIZE - 1));

    // First frame of a window loads the sample as-is; this also covers
    // POOL_SIZE==1, where the first frame is the emitting frame.
    assign pooled    = frm_first ? data_i : max_signed(acc_rdata, data_i);

    // The emitting frame goes straight to the output register; its
    // accumulator entry is dead until the next window reloads it.
    assign acc_we    = accept && !frm_last;

    max_pool_acc_mem #(
        .BW     (BW),
        .NUM_CH (NUM_CH)
    ) u_acc_mem (
        .clk_i   (clk_i),
        .we_i    (acc_we),
        .waddr_i (ch_cnt_q),
        .wdata_i (pooled),
        .raddr_i (ch_cnt_q),
        .rdata_o (acc_rdata)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ch_cnt_d  = ch_cnt_q;
        frm_cnt_d = frm_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        trunc_d   = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // An emit in the same cycle as a drain reloads the register with no bubble.
        if (accept && frm_last) begin
            data_d  = pooled;
            valid_d = 1'b1;
            last_d  = last_i && ch_last;
        end

        if (accept) begin
            if (last_i) begin
                // Sequence end: restart at ch0/frame0; anything short of a
                // complete window is a dropped partial window.
                ch_cnt_d  = '0;
                frm_cnt_d = '0;
                trunc_d   = !(ch_last && frm_last);
            end else if (ch_last) begin
                ch_cnt_d  = '0;
                frm_cnt_d = frm_last ? '0 : frm_cnt_q + 1'b1;
            end else begin
                ch_cnt_d  = ch_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ch_cnt_q  <= '0;
            frm_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            ch_cnt_q  <= ch_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            trunc_q   <= trunc_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign trunc_o = trunc_q;

endmodule

// File: tb/tb_max_pool.sv
module tb_max_pool;

    localparam int N_INST = 4;
    // inst0: 2ch/pool2, inst1: 1ch/pool3, inst2: 1ch/pool1, inst3: 8ch/pool2
    localparam int NC_A [N_INST] = '{2, 1, 1, 8};
    localparam int PS_A [N_INST] = '{2, 3, 1, 2};

    typedef struct {
        int data;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [N_INST];
    logic [31:0] din     [N_INST];
    logic        vin     [N_INST];
    logic        lin     [N_INST];
    logic        ready_i [N_INST] = '{default: 1'b1};
    wire  [31:0] dout    [N_INST];
    wire         vout    [N_INST];
    wire         lout    [N_INST];
    wire         ready_o [N_INST];
    wire         trunc   [N_INST];

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        max_pool #(
            .BW        (32),
            .NUM_CH    (NC_A[g]),
            .POOL_SIZE (PS_A[g])
        ) u_dut (
            .clk_i   (clk),
            .rst_n_i (rst_n[g]),
            .data_i  (din[g]),
            .valid_i (vin[g]),
            .last_i  (lin[g]),
            .ready_o (ready_o[g]),
            .data_o  (dout[g]),
            .valid_o (vout[g]),
            .last_o  (lout[g]),
            .ready_i (ready_i[g]),
            .trunc_o (trunc[g])
        );
    end

    // Reference model state: raw samples of the current window, pending outputs.
    int    win       [N_INST][$];
    beat_t exp_q     [N_INST][$];
    bit    exp_trunc [N_INST];
    int    got_d     [N_INST][$];
    bit    got_l     [N_INST][$];
    int    trunc_cnt [N_INST];
    bit    ready_rand[N_INST];
    bit    ready_man [N_INST];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    chk_en = 1'b0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0d (0x%h) want %0d (0x%h) at %0t",
                     name, inst, $signed(act), act, $signed(exp), exp, $time);
        end
    endtask

    // Window position k -> (frame, channel). Outputs come from final-frame
    // beats as the max over all frames of that channel in the window.
    function automatic void model_beat(input int i, input int d, input bit l);
        int    nc;
        int    ps;
        int    k;
        int    ch;
        int    fr;
        beat_t e;
        nc = NC_A[i];
        ps = PS_A[i];
        k  = win[i].size();
        ch = k % nc;
        fr = k / nc;
        win[i].push_back(d);
        if (fr == ps - 1) begin
            e.data = win[i][ch];
            for (int f = 1; f < ps; f++) begin
                if (win[i][f*nc + ch] > e.data) e.data = win[i][f*nc + ch];
            end
            e.last = l && (k == nc*ps - 1);
            exp_q[i].push_back(e);
        end
        if (l) begin
            if (k != nc*ps - 1) exp_trunc[i] = 1'b1;
            win[i].delete();
        end else if (k == nc*ps - 1) begin
            win[i].delete();
        end
    endfunction

    // Single compare process: outputs first (state after the last edge), then
    // fold this cycle's accepted input into the model.
    always @(negedge clk) begin
        beat_t e;
        if (chk_en) begin
            for (int i = 0; i < N_INST; i++) begin
                check("ready_o", i, 32'(ready_o[i]), 32'(!vout[i] || ready_i[i]));
                check("valid_o", i, 32'(vout[i]), 32'(exp_q[i].size() != 0));
                check("trunc_o", i, 32'(trunc[i]), 32'(exp_trunc[i]));
                if (trunc[i] === 1'b1) trunc_cnt[i]++;
                exp_trunc[i] = 1'b0;
                if (vout[i] === 1'b1 && ready_i[i] && exp_q[i].size() != 0) begin
                    e = exp_q[i].pop_front();
                    check("data_o", i, dout[i], e.data);
                    check("last_o", i, 32'(lout[i]), 32'(e.last));
                    got_d[i].push_back(int'(dout[i]));
                    got_l[i].push_back(lout[i]);
                end
                if (!rst_n[i]) begin
                    win[i].delete();
                    exp_q[i].delete();
                    exp_trunc[i] = 1'b0;
                end else if (vin[i] && ready_o[i]) begin
                    model_beat(i, int'(din[i]), lin[i]);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N_INST; i++) begin
            ready_i[i] = ready_rand[i] ? ($urandom_range(0, 3) != 0) : ready_man[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input int i, input int d, input bit l, input int gap);
        int budget;
        budget  = 300;
        din[i]  = d;
        lin[i]  = l;
        vin[i]  = 1'b1;
        @(negedge clk);
        while (ready_o[i] !== 1'b1 && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout inst%0d: ready_o stuck low, want 1", i);
        end
        @(posedge clk);
        #1;
        vin[i] = 1'b0;
        lin[i] = 1'b0;
        tick(gap);
    endtask

    task automatic drain(input int i);
        int budget;
        budget = 300;
        tick(2);
        while ((exp_q[i].size() != 0 || vout[i] !== 1'b0) && budget > 0) begin
            budget--;
            tick(1);
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout inst%0d: %0d outputs pending, want 0", i, exp_q[i].size());
        end
    endtask

    task automatic clear_log(input int i);
        got_d[i].delete();
        got_l[i].delete();
    endtask

    task automatic check_out(input string name, input int i, input int k,
                             input int d, input bit l);
        if (got_d[i].size() <= k) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s inst%0d: output %0d missing, got %0d outputs", name, i, k, got_d[i].size());
        end else begin
            check({name, "_data"}, i, got_d[i][k], d);
            check({name, "_last"}, i, 32'(got_l[i][k]), 32'(l));
        end
    endtask

    function automatic int pick();
        case ($urandom_range(0, 7))
            0:       return int'(32'h8000_0000);
            1:       return int'(32'h7fff_ffff);
            2:       return -1;
            3:       return 0;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic run_rand(input int i, input int n);
        for (int b = 0; b < n; b++) begin
            send(i, pick(), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
    endtask

    initial begin
        int base;
        for (int i = 0; i < N_INST; i++) begin
            rst_n[i]     = 1'b0;
            vin[i]       = 1'b0;
            lin[i]       = 1'b0;
            din[i]       = '0;
            ready_man[i] = 1'b1;
            ready_rand[i]= 1'b0;
            trunc_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick(1);
        for (int i = 0; i < N_INST; i++) begin
            check("reset_data_o", i, dout[i], 32'd0);
            check("reset_last_o", i, 32'(lout[i]), 32'd0);
            rst_n[i] = 1'b1;
        end

        // 2ch/pool2, no stall: (3,-5)(7,-9) -> 7, -5(last)
        clear_log(0);
        send(0, 3, 0, 0); send(0, -5, 0, 0); send(0, 7, 0, 0); send(0, -9, 1, 0);
        drain(0);
        check("basic_count", 0, got_d[0].size(), 2);
        check_out("basic0", 0, 0, 7, 0);
        check_out("basic1", 0, 1, -5, 1);

        // Same stream, output held for 3 cycles after the first result
        ready_man[0] = 1'b0;
        tick(1);
        clear_log(0);
        fork
            begin
                send(0, 3, 0, 0); send(0, -5, 0, 0); send(0, 7, 0, 0); send(0, -9, 1, 0);
            end
            begin
                int budget;
                budget = 50;
                @(negedge clk);
                while (vout[0] !== 1'b1 && budget > 0) begin
                    budget--;
                    @(negedge clk);
                end
                for (int c = 0; c < 3; c++) begin
                    check("stall_ready_o", 0, 32'(ready_o[0]), 32'd0);
                    check("stall_data_o", 0, dout[0], 32'd7);
                    if (c < 2) @(negedge clk);
                end
                ready_man[0] = 1'b1;
            end
        join
        drain(0);
        check("stall_count", 0, got_d[0].size(), 2);
        check_out("stall0", 0, 0, 7, 0);
        check_out("stall1", 0, 1, -5, 1);

        // 1ch/pool3: 1,1,4,2,9,0(last) -> 4, 9(last), no trunc
        clear_log(1);
        base = trunc_cnt[1];
        foreach (PS_A[k]) begin end
        send(1, 1, 0, 0); send(1, 1, 0, 0); send(1, 4, 0, 0);
        send(1, 2, 0, 0); send(1, 9, 0, 0); send(1, 0, 1, 0);
        drain(1);
        check_out("pool3_0", 1, 0, 4, 0);
        check_out("pool3_1", 1, 1, 9, 1);
        check("pool3_trunc", 1, trunc_cnt[1] - base, 0);

        // Early last on f1/ch0: ch0 still emitted, trunc once, next sequence clean
        clear_log(0);
        base = trunc_cnt[0];
        send(0, 1, 0, 0); send(0, 2, 0, 0); send(0, 5, 1, 0);
        drain(0);
        check("early_count", 0, got_d[0].size(), 1);
        check_out("early0", 0, 0, 5, 0);
        check("early_trunc", 0, trunc_cnt[0] - base, 1);
        clear_log(0);
        send(0, 4, 0, 0); send(0, 8, 0, 0); send(0, 6, 0, 0); send(0, -1, 1, 0);
        drain(0);
        check_out("after_early0", 0, 0, 6, 0);
        check_out("after_early1", 0, 1, 8, 1);

        // Reset mid-window after 3 beats
        send(0, 100, 0, 0); send(0, 200, 0, 0); send(0, 300, 0, 0);
        rst_n[0] = 1'b0;
        tick(1);
        rst_n[0] = 1'b1;
        check("midrst_valid_o", 0, 32'(vout[0]), 32'd0);
        check("midrst_data_o", 0, dout[0], 32'd0);
        clear_log(0);
        send(0, 10, 0, 0); send(0, 20, 0, 0); send(0, 5, 0, 0); send(0, 30, 1, 0);
        drain(0);
        check_out("postrst0", 0, 0, 10, 0);
        check_out("postrst1", 0, 1, 30, 1);

        // Pool1 passthrough, negative values, back-to-back
        clear_log(2);
        send(2, -1, 0, 0); send(2, -128, 1, 0);
        drain(2);
        check_out("pass0", 2, 0, -1, 0);
        check_out("pass1", 2, 1, -128, 1);

        // Randomized traffic on all instances with random backpressure
        for (int i = 0; i < N_INST; i++) ready_rand[i] = 1'b1;
        for (int i = 0; i < N_INST; i++) begin
            automatic int k = i;
            fork
                run_rand(k, 300);
            join_none
        end
        wait fork;
        for (int i = 0; i < N_INST; i++) ready_rand[i] = 1'b0;
        for (int i = 0; i < N_INST; i++) drain(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
